// File: rtl/panel_pkg.sv
// Shared definitions for the panel stage: mode encodings, loader states and default timing.
package panel_pkg;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_CHECK = 2'b10;
  localparam logic [1:0] MODE_RUN   = 2'b11;

  typedef enum logic [3:0] {
    LD_IDLE    = 4'd0,
    LD_ENTER   = 4'd1,
    LD_PRESENT = 4'd2,
    LD_STROBE  = 4'd3,
    LD_GAP     = 4'd4,
    LD_FINISH  = 4'd5,
    LD_HOLD    = 4'd6,
    LD_VERIFY  = 4'd7,
    LD_VSTROBE = 4'd8,
    LD_VGAP    = 4'd9
  } loader_state_e;

  // Plain-vector copies of the states for the legacy-style state register
  localparam logic [3:0] ST_IDLE    = LD_IDLE;
  localparam logic [3:0] ST_ENTER   = LD_ENTER;
  localparam logic [3:0] ST_PRESENT = LD_PRESENT;
  localparam logic [3:0] ST_STROBE  = LD_STROBE;
  localparam logic [3:0] ST_GAP     = LD_GAP;
  localparam logic [3:0] ST_FINISH  = LD_FINISH;
  localparam logic [3:0] ST_HOLD    = LD_HOLD;
  localparam logic [3:0] ST_VERIFY  = LD_VERIFY;
  localparam logic [3:0] ST_VSTROBE = LD_VSTROBE;
  localparam logic [3:0] ST_VGAP    = LD_VGAP;

  localparam int DEF_ADDR_W        = 8;
  localparam int DEF_STROBE_CYCLES = 8;
  localparam int DEF_GAP_CYCLES    = 8;
  localparam int DEF_SETTLE_CYCLES = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Panel bus between the loader and the CPU/RAM/display top level.
// PROG_LOADER_VERIFY_EN adds the RAM check_out readback byte.
interface prog_loader_if;
  logic       sw1;
  logic       sw2;
  logic       a1;
  logic [7:0] d;
`ifdef PROG_LOADER_VERIFY_EN
  logic [7:0] check_in;

  modport master (output sw1, sw2, a1, d, input check_in);
  modport slave  (input sw1, sw2, a1, d, output check_in);
`else
  modport master (output sw1, sw2, a1, d);
  modport slave  (input sw1, sw2, a1, d);
`endif
endinterface

// File: rtl/loader_rom.sv
// Program image for the loader; combinational read. Bytes 0..2 hold the
// bring-up program, the rest a fixed address-derived fill pattern.
module loader_rom #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  // ROM lookup
  always_comb begin
    case (addr)
      ADDR_W'(0): data = 8'h11;
      ADDR_W'(1): data = 8'h22;
      ADDR_W'(2): data = 8'h33;
      default:    data = 8'(addr) ^ 8'h5A;
    endcase
  end

endmodule

// File: rtl/prog_loader.sv
// Panel loader: passes manual switches through when idle, and on start writes
// the ROM image into RAM via timed A1 strobes. Optional: PROG_LOADER_VERIFY_EN.
module prog_loader
  import panel_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int AUTO_RUN      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              man_sw1,
  input  logic              man_sw2,
  input  logic              man_a1,
  input  logic [7:0]        man_d,
  prog_loader_if.master     pnl,
  output logic              busy,
  output logic              done,
`ifdef PROG_LOADER_VERIFY_EN
  output logic              verr,
  output logic [ADDR_W-1:0] err_idx,
`endif
  output logic [ADDR_W-1:0] load_idx
);

  localparam int CNT_W = $clog2(max3(STROBE_CYCLES, GAP_CYCLES, SETTLE_CYCLES)) + 1;
  localparam logic [1:0] FINAL_MODE = (AUTO_RUN != 0) ? MODE_RUN : MODE_STOP;

  function automatic logic [CNT_W-1:0] cyc(input int n);
    return CNT_W'(n - 1);
  endfunction

  logic [3:0]        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W:0]   len_r, len_s;
  logic [ADDR_W-1:0] idx_r, idx_s, rom_addr_s;
  logic              sw1_r, sw1_s, sw2_r, sw2_s, a1_r, a1_s;
  logic [7:0]        d_r, d_s, rom_s;
  logic              busy_r, busy_s, done_r, done_s;
  logic              cnt_done_s, last_s;
`ifdef PROG_LOADER_VERIFY_EN
  logic              verr_r, verr_s;
  logic [ADDR_W-1:0] err_idx_r, err_idx_s;
`endif

  // In GAP the next byte is fetched ahead so it lands in d on entry to PRESENT
  assign rom_addr_s = (state_r == ST_GAP) ? (idx_r + ADDR_W'(1)) : idx_r;
  assign cnt_done_s = (cnt_r == '0);
  assign last_s     = ({1'b0, idx_r} == (len_r - (ADDR_W+1)'(1)));

  loader_rom #(.ADDR_W(ADDR_W)) u_rom (
    .addr (rom_addr_s),
    .data (rom_s)
  );

  // Next-state and next-output computation for the load sequencer
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_done_s ? cnt_r : (cnt_r - CNT_W'(1));
    len_s   = len_r;
    idx_s   = idx_r;
    busy_s  = busy_r;
    done_s  = done_r;
    sw1_s   = sw1_r;
    sw2_s   = sw2_r;
    a1_s    = a1_r;
    d_s     = d_r;
`ifdef PROG_LOADER_VERIFY_EN
    verr_s    = verr_r;
    err_idx_s = err_idx_r;
`endif
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if (start) begin
          state_s        = ST_ENTER;
          cnt_s          = cyc(SETTLE_CYCLES);
          len_s          = prog_len;
          idx_s          = '0;
          busy_s         = 1'b1;
          done_s         = 1'b0;
          {sw1_s, sw2_s} = MODE_LOAD;
          a1_s           = 1'b0;
          d_s            = 8'h00;
`ifdef PROG_LOADER_VERIFY_EN
          verr_s    = 1'b0;
          err_idx_s = '0;
`endif
        end else if ((state_r == ST_IDLE) || ({man_sw1, man_sw2} != FINAL_MODE)) begin
          state_s = ST_IDLE;
          sw1_s   = man_sw1;
          sw2_s   = man_sw2;
          a1_s    = man_a1;
          d_s     = man_d;
        end else begin
          {sw1_s, sw2_s} = FINAL_MODE;
          a1_s           = 1'b0;
          d_s            = 8'h00;
        end
      end
      ST_ENTER: begin
        if (cnt_done_s && (len_r == '0)) begin
          state_s        = ST_FINISH;
          {sw1_s, sw2_s} = FINAL_MODE;
        end else if (cnt_done_s) begin
          state_s = ST_PRESENT;
          cnt_s   = cyc(GAP_CYCLES);
          d_s     = rom_s;
        end else begin
          state_s = ST_ENTER;
        end
      end
      ST_PRESENT: begin
        if (cnt_done_s) begin
          state_s = ST_STROBE;
          cnt_s   = cyc(STROBE_CYCLES);
          a1_s    = 1'b1;
        end else begin
          state_s = ST_PRESENT;
        end
      end
      ST_STROBE: begin
        if (cnt_done_s) begin
          state_s = ST_GAP;
          cnt_s   = cyc(GAP_CYCLES);
          a1_s    = 1'b0;
        end else begin
          state_s = ST_STROBE;
        end
      end
      ST_GAP: begin
        if (cnt_done_s && last_s) begin
`ifdef PROG_LOADER_VERIFY_EN
          state_s        = ST_VERIFY;
          cnt_s          = cyc(GAP_CYCLES);
          idx_s          = '0;
          {sw1_s, sw2_s} = MODE_CHECK;
          d_s            = 8'h00;
`else
          state_s        = ST_FINISH;
          {sw1_s, sw2_s} = FINAL_MODE;
          d_s            = 8'h00;
`endif
        end else if (cnt_done_s) begin
          state_s = ST_PRESENT;
          cnt_s   = cyc(GAP_CYCLES);
          idx_s   = idx_r + ADDR_W'(1);
          d_s     = rom_s;
        end else begin
          state_s = ST_GAP;
        end
      end
`ifdef PROG_LOADER_VERIFY_EN
      ST_VERIFY: begin
        if (cnt_done_s) begin
          state_s = ST_VSTROBE;
          cnt_s   = cyc(STROBE_CYCLES);
          a1_s    = 1'b1;
        end else begin
          state_s = ST_VERIFY;
        end
      end
      ST_VSTROBE: begin
        if (cnt_done_s) begin
          state_s = ST_VGAP;
          cnt_s   = cyc(GAP_CYCLES);
          a1_s    = 1'b0;
        end else begin
          state_s = ST_VSTROBE;
        end
      end
      ST_VGAP: begin
        // rom_s is addressed by idx_r here, so it is the byte under check
        if (cnt_done_s && (pnl.check_in != rom_s) && !verr_r) begin
          verr_s    = 1'b1;
          err_idx_s = idx_r;
        end else begin
          verr_s = verr_r;
        end
        if (cnt_done_s && last_s) begin
          state_s        = ST_FINISH;
          {sw1_s, sw2_s} = FINAL_MODE;
        end else if (cnt_done_s) begin
          state_s = ST_VSTROBE;
          cnt_s   = cyc(STROBE_CYCLES);
          idx_s   = idx_r + ADDR_W'(1);
          a1_s    = 1'b1;
        end else begin
          state_s = ST_VGAP;
        end
      end
`endif
      ST_FINISH: begin
        state_s        = ST_HOLD;
        busy_s         = 1'b0;
        done_s         = 1'b1;
        {sw1_s, sw2_s} = FINAL_MODE;
        a1_s           = 1'b0;
        d_s            = 8'h00;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        a1_s    = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset clears everything on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      len_r   <= '0;
      idx_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sw1_r   <= 1'b0;
      sw2_r   <= 1'b0;
      a1_r    <= 1'b0;
      d_r     <= 8'h00;
`ifdef PROG_LOADER_VERIFY_EN
      verr_r    <= 1'b0;
      err_idx_r <= '0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      len_r   <= len_s;
      idx_r   <= idx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      sw1_r   <= sw1_s;
      sw2_r   <= sw2_s;
      a1_r    <= a1_s;
      d_r     <= d_s;
`ifdef PROG_LOADER_VERIFY_EN
      verr_r    <= verr_s;
      err_idx_r <= err_idx_s;
`endif
    end
  end

  assign pnl.sw1  = sw1_r;
  assign pnl.sw2  = sw2_r;
  assign pnl.a1   = a1_r;
  assign pnl.d    = d_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign load_idx = idx_r;
`ifdef PROG_LOADER_VERIFY_EN
  assign verr    = verr_r;
  assign err_idx = err_idx_r;
`endif

endmodule
